window_generator: RTL



---
 rtl/window_generator.sv | 120 ++++++++++++
 1 files changed

// File: rtl/window_generator.sv
// Raster-order pixel stream to WIN x WIN sliding window with a one-cycle windowF strobe.
// Optional FRAME_DONE_EN macro adds a frame_done pulse on the last pixel of a full frame.
module window_generator #(
    parameter int DATA_WIDTH = 8,
    parameter int WIN        = 5,
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64,
    localparam int WINDOW_BITS = WIN * WIN * DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  pix_in,
    input  logic                   pix_valid,
    input  logic                   pix_sof,
`ifdef FRAME_DONE_EN
    output logic                   frame_done,
`endif
    output logic [WINDOW_BITS-1:0] out,
    output logic                   windowF,
    output logic [DATA_WIDTH-1:0]  wCenter
);

    localparam int CW   = $clog2(IMG_WIDTH);
    localparam int RW   = $clog2(IMG_HEIGHT);
    localparam int NPIX = WIN * WIN;
    localparam int CIDX = (NPIX - 1) / 2;

    logic [CW-1:0] col, acol;
    logic [RW-1:0] row, arow;

    logic [DATA_WIDTH-1:0] lb       [WIN-1][IMG_WIDTH];
    logic [DATA_WIDTH-1:0] column   [WIN];
    logic [DATA_WIDTH-1:0] win      [NPIX];
    logic [DATA_WIDTH-1:0] win_next [NPIX];

    logic last_col, last_row, in_window;

    // A start-of-frame pixel is placed at (0,0) regardless of where the counters are.
    assign acol      = pix_sof ? '0 : col;
    assign arow      = pix_sof ? '0 : row;
    assign last_col  = (acol == CW'(IMG_WIDTH - 1));
    assign last_row  = (arow == RW'(IMG_HEIGHT - 1));
    assign in_window = (arow >= RW'(WIN - 1)) && (acol >= CW'(WIN - 1));

    // Buffer 0 holds the oldest line; each accepted pixel ripples its column up one line.
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            for (int r = 0; r < WIN - 2; r++) begin
                lb[r][acol] <= lb[r + 1][acol];
            end
            lb[WIN-2][acol] <= pix_in;
        end
    end

    always_comb begin
        for (int r = 0; r < WIN; r++) begin
            column[r] = '0;
        end
        for (int r = 0; r < WIN - 1; r++) begin
            column[r] = lb[r][acol];
        end
        column[WIN-1] = pix_in;
    end

    always_comb begin
        for (int i = 0; i < NPIX; i++) begin
            win_next[i] = '0;
        end
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                if (c == WIN - 1) begin
                    win_next[r*WIN + c] = column[r];
                end else begin
                    win_next[r*WIN + c] = win[r*WIN + c + 1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win     <= '{default: '0};
            wCenter <= '0;
            windowF <= 1'b0;
            col     <= '0;
            row     <= '0;
        end else begin
            windowF <= pix_valid && in_window;
            if (pix_valid) begin
                win     <= win_next;
                wCenter <= win_next[CIDX];
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : arow + 1'b1;
                end else begin
                    col <= acol + 1'b1;
                    row <= arow;
                end
            end
        end
    end

`ifdef FRAME_DONE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= pix_valid && last_row && last_col;
        end
    end
`endif

    always_comb begin
        out = '0;
        for (int i = 0; i < NPIX; i++) begin
            out[DATA_WIDTH*i +: DATA_WIDTH] = win[i];
        end
    end

endmodule
